// File: rtl/cnn_layer_seq.sv
// Layer sequencer for a CNN PE array: streams weights into per-PE buffers,
// then issues compute steps with first/last qualifiers and drains the pipeline.
module cnn_layer_seq #(
    parameter int DATA_WID  = 16,
    parameter int ICP_NUM   = 8,
    parameter int OCP_NUM   = 8,
    parameter int ADDR_B    = 6,
    parameter int DRAIN_CYC = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_B:0]               w_len,
    input  logic [ADDR_B:0]               c_len,
    input  logic                          w_valid,
    input  logic [ICP_NUM*DATA_WID-1:0]   w_data,
    output logic                          w_ready,
    input  logic                          a_valid,
    output logic                          a_ready,
    output logic [OCP_NUM-1:0]            wrb,
    output logic [ADDR_B-1:0]             wrb_addr,
    output logic [ICP_NUM*DATA_WID-1:0]   wrb_data,
    output logic [ADDR_B-1:0]             rdb_addr,
    output logic                          pe_valid,
    output logic                          pe_first,
    output logic                          pe_last,
    output logic                          busy,
    output logic                          done
);
    localparam int PE_W  = (OCP_NUM > 1) ? $clog2(OCP_NUM) : 1;
    localparam int LEN_W = ADDR_B + 1;
    localparam int DC_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(1) << ADDR_B;
    localparam logic [PE_W-1:0]  PE_LAST  = PE_W'(OCP_NUM - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    state_t              state_reg;
    logic [LEN_W-1:0]    w_len_reg;
    logic [LEN_W-1:0]    c_len_reg;
    logic [ADDR_B-1:0]   w_cnt_reg;
    logic [ADDR_B-1:0]   c_cnt_reg;
    logic [PE_W-1:0]     pe_idx_reg;
    logic [DC_W-1:0]     d_cnt_reg;

    logic [LEN_W-1:0]    w_len_sat;
    logic [LEN_W-1:0]    c_len_sat;
    logic                w_hs;
    logic                a_hs;
    logic                w_last;
    logic                c_last;

    // Lengths beyond the buffer depth are clipped so counters never overrun.
    assign w_len_sat = (w_len > LEN_MAX) ? LEN_MAX : w_len;
    assign c_len_sat = (c_len > LEN_MAX) ? LEN_MAX : c_len;

    // Reset gates every output so the array sees silence during the reset cycle too.
    assign w_hs   = !reset && (state_reg == LOAD_W) && w_valid;
    assign a_hs   = !reset && (state_reg == COMPUTE) && a_valid;
    assign w_last = ({1'b0, w_cnt_reg} == (w_len_reg - LEN_W'(1)));
    assign c_last = ({1'b0, c_cnt_reg} == (c_len_reg - LEN_W'(1)));

    assign w_ready  = !reset && (state_reg == LOAD_W);
    assign a_ready  = !reset && (state_reg == COMPUTE);
    assign wrb_addr = w_hs ? w_cnt_reg : '0;
    assign wrb_data = w_hs ? w_data : '0;
    assign pe_valid = a_hs;
    assign rdb_addr = a_hs ? c_cnt_reg : '0;
    assign pe_first = a_hs && (c_cnt_reg == '0);
    assign pe_last  = a_hs && c_last;
    assign busy     = !reset && (state_reg != IDLE);
    assign done     = !reset && (state_reg == DONE);

    generate
        for (genvar gi = 0; gi < OCP_NUM; gi++) begin : g_wrb
            assign wrb[gi] = w_hs && (pe_idx_reg == PE_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            w_len_reg  <= '0;
            c_len_reg  <= '0;
            w_cnt_reg  <= '0;
            c_cnt_reg  <= '0;
            pe_idx_reg <= '0;
            d_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_len_reg  <= w_len_sat;
                        c_len_reg  <= c_len_sat;
                        w_cnt_reg  <= '0;
                        c_cnt_reg  <= '0;
                        pe_idx_reg <= '0;
                        d_cnt_reg  <= '0;
                        if (w_len_sat != '0)
                            state_reg <= LOAD_W;
                        else if (c_len_sat != '0)
                            state_reg <= COMPUTE;
                        else
                            state_reg <= DONE;
                    end
                end
                LOAD_W: begin
                    if (w_valid) begin
                        if (w_last) begin
                            w_cnt_reg <= '0;
                            if (pe_idx_reg == PE_LAST) begin
                                pe_idx_reg <= '0;
                                state_reg  <= (c_len_reg != '0) ? COMPUTE : DONE;
                            end else begin
                                pe_idx_reg <= pe_idx_reg + 1'b1;
                            end
                        end else begin
                            w_cnt_reg <= w_cnt_reg + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (a_valid) begin
                        if (c_last) begin
                            c_cnt_reg <= '0;
                            d_cnt_reg <= '0;
                            state_reg <= (DRAIN_CYC > 0) ? DRAIN : DONE;
                        end else begin
                            c_cnt_reg <= c_cnt_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (d_cnt_reg == DC_LAST)
                        state_reg <= DONE;
                    else
                        d_cnt_reg <= d_cnt_reg + 1'b1;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
